par_err_scan: RTL and testbench
===============================

Name: par_err_scan

Overview:
- Parametrised, sequential successor to the combinational 4-bit parity error identifier.
- On `start`, snapshots CH words of W bits each and flags every word whose parity is wrong.
- Streams each erroneous word with its channel index over a valid/ready handshake, highest channel first.
- Reports an error flag and an error count, then pulses `done`. Sits between the data-capture stage and the error logger/display.

Parameters:
- CH, 8, number of channels (≥2)
- W, 4, word width per channel in bits (≥2)
- ODD, 0, parity mode: 0 = even parity valid, 1 = odd parity valid

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  capture request; sampled only in IDLE
- din  in  CH*W  packed channel words; channel k = din[k*W +: W]
- busy  out  1  high while state ≠ IDLE
- out_valid  out  1  an erroneous word is presented
- out_ready  in  1  consumer accepts the presented word
- out_data  out  W  presented word, from the snapshot
- out_idx  out  $clog2(CH)  presented channel index
- err_any  out  1  snapshot contained ≥1 error; held until next capture
- err_cnt  out  $clog2(CH+1)  number of erroneous channels in the snapshot; held until next capture
- done  out  1  one-cycle pulse at end of scan

Behaviour:
- Channel error: err[k] = (^word_k) != ODD. With W=4 and ODD=0, the valid codes are exactly 0000, 0011, 0101, 0110, 1001, 1010, 1100, 1111.
- States: IDLE, SCAN, DONE.
- IDLE, start=1 at a rising edge:
  - snap <= din, mask <= err, err_cnt <= popcount(err), err_any <= |err.
  - Next state is SCAN if err ≠ 0, else DONE.
- SCAN:
  - out_valid = 1.
  - out_idx = highest set bit of mask (channel CH-1 has top priority).
  - out_data = snap word at out_idx.
  - All three are driven from registers only and are stable until accepted.
- Transfer occurs on a rising edge with out_valid & out_ready. That mask bit is cleared; the next error is presented the following cycle, giving a sustained throughput of 1 word/cycle.
- If the transfer clears the last remaining bit, the state goes to DONE at that same edge (no bubble).
- DONE: done = 1 for exactly one cycle, then IDLE.
- out_valid and done are never high in the same cycle.
- Latency:
  - Clean snapshot: done is high in the cycle after the start edge.
  - N errors with out_ready held high: out_valid is high for N consecutive cycles starting the cycle after the start edge; done follows immediately after.
- start while busy: ignored; no re-capture and no queueing. din changing during a scan has no effect.
- out_ready while out_valid = 0: ignored.
- In IDLE and DONE: out_data and out_idx = 0, out_valid = 0.
- Reset (asynchronous, any state including mid-scan):
  - State goes to IDLE; snap, mask, err_cnt, err_any, out_valid, done, busy, out_data and out_idx all go to 0.
  - Any word not yet transferred is discarded.
- err_cnt saturation cannot occur: its width holds CH.

Optional Feature:
- Macro: PAR_ERR_SCAN_HIST_EN
- When defined, adds two ports:
  - hist_clr  in  1
  - err_hist  out  CH — sticky per-channel OR of err across all captures since reset or the last hist_clr.
- err_hist updates at the capture edge; it is cleared by rst or by hist_clr.
- If hist_clr and a capture occur on the same edge, err_hist <= err (clear, then set from the new capture).
- When not defined: neither port exists, and no history register is built.

Test Plan:
1. CH=8, W=4, ODD=0; all channels 4'b0011; start pulse → no out_valid, done high in the following cycle, err_any=0, err_cnt=0.
2. ch7=0001, ch3=0111, ch0=1000, other channels 0000, out_ready=1 → (idx 7, data 1), (idx 3, data 7), (idx 0, data 8) on three consecutive cycles; done in the next cycle; err_cnt=3, err_any=1.
3. Same snapshot as scenario 2, out_ready=0 for 5 cycles, plus a start pulse and a changed din during the scan → idx 7 / data 1 held stable for all 5 cycles; the start is ignored; remaining output matches scenario 2 once out_ready=1.
4. rst asserted mid-scan after one transfer → all outputs 0 immediately, state IDLE; a following start with ch5=1110 yields a single transfer (idx 5, data 14), then done.
5. ODD=1, all channels 0000 → 8 transfers with idx 7 down to 0, err_cnt=8.
6. With PAR_ERR_SCAN_HIST_EN defined:
   - Capture with ch2 in error, then capture with ch6 in error → err_hist=8'h44.
   - hist_clr together with a capture with ch1 in error → err_hist=8'h02.

Source files
------------

// File: rtl/par_err_scan.sv
// Snapshot parity scanner: it captures CH words and streams the words with bad parity, highest channel first.
// Defining PAR_ERR_SCAN_HIST_EN adds a sticky per-channel error history with a clear input.
module par_err_scan #(
    parameter int CH  = 8,
    parameter int W   = 4,
    parameter int ODD = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CH*W-1:0]         din,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_data,
    output logic [$clog2(CH)-1:0]   out_idx,
    output logic                    err_any,
    output logic [$clog2(CH+1)-1:0] err_cnt,
`ifdef PAR_ERR_SCAN_HIST_EN
    input  logic                    hist_clr,
    output logic [CH-1:0]           err_hist,
`endif
    output logic                    done
);

    localparam int   IW      = $clog2(CH);
    localparam int   CW      = $clog2(CH+1);
    localparam logic ODD_BIT = (ODD != 0);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state, state_nxt;
    logic [CH*W-1:0] snap;
    logic [CH-1:0]   mask, mask_rem, err;
    logic            capture, xfer, last;

    function automatic logic [IW-1:0] msb(input logic [CH-1:0] m);
        logic [IW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < CH; i++)
            if (m[i]) r = IW'(i);
        return r;
    endfunction

    function automatic logic [W-1:0] word(input logic [CH*W-1:0] v, input logic [IW-1:0] k);
        logic [W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < CH; i++)
            if (IW'(i) == k) r = v[i*W +: W];
        return r;
    endfunction

    function automatic logic [CW-1:0] popcnt(input logic [CH-1:0] m);
        logic [CW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < CH; i++)
            r = r + CW'(m[i]);
        return r;
    endfunction

    always_comb begin
        err = '0;
        for (int unsigned k = 0; k < CH; k++)
            err[k] = (^din[k*W +: W]) ^ ODD_BIT;
    end

    // Mask with the presented channel removed; it decides the next index and the move to DONE.
    always_comb begin
        mask_rem          = mask;
        mask_rem[out_idx] = 1'b0;
        last              = (mask_rem == '0);
        capture           = (state == IDLE) && start;
        xfer              = (state == SCAN) && out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        out_valid = (state == SCAN);
        done      = (state == DONE);
        case (state)
            IDLE:    if (start) state_nxt = (|err) ? SCAN : DONE;
            SCAN:    if (out_ready && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The next index and word are registered one edge ahead, so the outputs never come from logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap     <= '0;
            mask     <= '0;
            err_cnt  <= '0;
            err_any  <= 1'b0;
            out_idx  <= '0;
            out_data <= '0;
        end else if (capture) begin
            snap     <= din;
            mask     <= err;
            err_cnt  <= popcnt(err);
            err_any  <= |err;
            out_idx  <= msb(err);
            out_data <= (|err) ? word(din, msb(err)) : '0;
        end else if (xfer) begin
            mask     <= mask_rem;
            out_idx  <= msb(mask_rem);
            out_data <= last ? '0 : word(snap, msb(mask_rem));
        end
    end

`ifdef PAR_ERR_SCAN_HIST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          err_hist <= '0;
        else if (capture) err_hist <= (hist_clr ? '0 : err_hist) | err;
        else if (hist_clr) err_hist <= '0;
    end
`endif

endmodule

// File: tb/tb_par_err_scan.sv
// Bench for par_err_scan: a queue-based model is compared against the DUT on every cycle, and directed literal checks pin that model.
module tb_par_err_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] din = '0;

    logic        busy, out_valid, done, err_any;
    logic [3:0]  out_data;
    logic [2:0]  out_idx;
    logic [3:0]  err_cnt;

    logic        o_busy, o_out_valid, o_done, o_err_any;
    logic [3:0]  o_out_data;
    logic [2:0]  o_out_idx;
    logic [3:0]  o_err_cnt;

`ifdef PAR_ERR_SCAN_HIST_EN
    logic        hist_clr = 1'b0;
    logic [7:0]  err_hist, o_err_hist;
`endif

    int nchk = 0;
    int nerr = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    par_err_scan #(.CH(8), .W(4), .ODD(0)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .err_any(err_any), .err_cnt(err_cnt),
`ifdef PAR_ERR_SCAN_HIST_EN
        .hist_clr(hist_clr), .err_hist(err_hist),
`endif
        .done(done)
    );

    par_err_scan #(.CH(8), .W(4), .ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .start(start2), .din(din), .busy(o_busy),
        .out_valid(o_out_valid), .out_ready(out_ready), .out_data(o_out_data),
        .out_idx(o_out_idx), .err_any(o_err_any), .err_cnt(o_err_cnt),
`ifdef PAR_ERR_SCAN_HIST_EN
        .hist_clr(1'b0), .err_hist(o_err_hist),
`endif
        .done(o_done)
    );

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of pending erroneous words, highest channel first, plus a one-cycle done flag.
    typedef struct { int idx; int data; } ent_t;
    ent_t q[$];
    bit   m_done;
    int   m_cnt, m_any;
    logic [7:0] m_hist;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_done = 0; m_cnt = 0; m_any = 0; m_hist = '0;
        end else begin
            logic [7:0] ev;
            bit         cap;
            ev  = '0;
            cap = 0;
            if (m_done) begin
                m_done = 0;
            end else if (q.size() != 0) begin
                if (out_ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) m_done = 1;
                end
            end else if (start) begin
                cap = 1;
                for (int k = 7; k >= 0; k--) begin
                    logic [3:0] w;
                    w = din[k*4 +: 4];
                    if (($countones(w) % 2) != 0) begin
                        q.push_back('{idx: k, data: int'(w)});
                        ev[k] = 1'b1;
                    end
                end
                m_cnt = q.size();
                m_any = (m_cnt > 0) ? 1 : 0;
                if (m_cnt == 0) m_done = 1;
            end
`ifdef PAR_ERR_SCAN_HIST_EN
            if (hist_clr) m_hist = '0;
`endif
            if (cap) m_hist = m_hist | ev;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int v;
            v = (q.size() != 0) ? 1 : 0;
            check("out_valid", int'(out_valid), v);
            check("out_idx",   int'(out_idx),  v ? q[0].idx  : 0);
            check("out_data",  int'(out_data), v ? q[0].data : 0);
            check("done",      int'(done),     int'(m_done));
            check("busy",      int'(busy),     (v || m_done) ? 1 : 0);
            check("err_cnt",   int'(err_cnt),  m_cnt);
            check("err_any",   int'(err_any),  m_any);
`ifdef PAR_ERR_SCAN_HIST_EN
            check("err_hist",  int'(err_hist), int'(m_hist));
`endif
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_cnt",   int'(err_cnt), 0);
        rst = 1'b0;
        chk_en = 1;
        tick();

        // 1: clean snapshot
        din = {8{4'b0011}}; start = 1'b1; out_ready = 1'b1;
        tick(); start = 1'b0;
        @(negedge clk);
        check("t1_done", int'(done), 1);
        check("t1_valid", int'(out_valid), 0);
        check("t1_any", int'(err_any), 0);
        check("t1_cnt", int'(err_cnt), 0);
        tick(); tick();

        // 2: three errors streamed back-to-back
        din = {4'h1, 4'h0, 4'h0, 4'h0, 4'h7, 4'h0, 4'h0, 4'h8};
        start = 1'b1;
        tick(); start = 1'b0;
        @(negedge clk); check("t2_idx0", int'(out_idx), 7); check("t2_dat0", int'(out_data), 1);
        tick();
        @(negedge clk); check("t2_idx1", int'(out_idx), 3); check("t2_dat1", int'(out_data), 7);
        tick();
        @(negedge clk); check("t2_idx2", int'(out_idx), 0); check("t2_dat2", int'(out_data), 8);
        tick();
        @(negedge clk); check("t2_done", int'(done), 1); check("t2_cnt", int'(err_cnt), 3);
        check("t2_any", int'(err_any), 1);
        tick(); tick();

        // 3: back-pressure, with start and din disturbed mid-scan
        out_ready = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_idx", int'(out_idx), 7);
            check("t3_hold_dat", int'(out_data), 1);
            check("t3_hold_vld", int'(out_valid), 1);
            if (i == 2) begin start = 1'b1; din = {8{4'h1}}; end
            tick();
            start = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk); check("t3_idx0", int'(out_idx), 7);
        tick();
        @(negedge clk); check("t3_idx1", int'(out_idx), 3); check("t3_dat1", int'(out_data), 7);
        tick();
        @(negedge clk); check("t3_idx2", int'(out_idx), 0); check("t3_dat2", int'(out_data), 8);
        tick();
        @(negedge clk); check("t3_done", int'(done), 1); check("t3_cnt", int'(err_cnt), 3);
        tick(); tick();

        // 4: asynchronous reset after one transfer
        din = {4'h1, 4'h0, 4'h0, 4'h0, 4'h7, 4'h0, 4'h0, 4'h8};
        start = 1'b1;
        tick(); start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("t4_rst_valid", int'(out_valid), 0);
        check("t4_rst_idx",   int'(out_idx), 0);
        check("t4_rst_data",  int'(out_data), 0);
        check("t4_rst_busy",  int'(busy), 0);
        check("t4_rst_cnt",   int'(err_cnt), 0);
        check("t4_rst_any",   int'(err_any), 0);
        @(negedge clk); rst = 1'b0;
        tick();
        din = 32'h00E0_0000; start = 1'b1;
        tick(); start = 1'b0;
        @(negedge clk); check("t4_idx", int'(out_idx), 5); check("t4_dat", int'(out_data), 14);
        tick();
        @(negedge clk); check("t4_done", int'(done), 1); check("t4_cnt", int'(err_cnt), 1);
        tick(); tick();

        // 5: odd-parity instance, every channel zero is an error
        din = '0; start2 = 1'b1;
        tick(); start2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t5_vld", int'(o_out_valid), 1);
            check("t5_idx", int'(o_out_idx), 7 - i);
            check("t5_dat", int'(o_out_data), 0);
            check("t5_busy", int'(o_busy), 1);
            tick();
        end
        @(negedge clk);
        check("t5_done", int'(o_done), 1);
        check("t5_vld_off", int'(o_out_valid), 0);
        check("t5_cnt", int'(o_err_cnt), 8);
        check("t5_any", int'(o_err_any), 1);
`ifdef PAR_ERR_SCAN_HIST_EN
        check("t5_hist", int'(o_err_hist), 8'hFF);
`endif
        tick(); tick();

`ifdef PAR_ERR_SCAN_HIST_EN
        // 6: sticky history and clear-with-capture
        hist_clr = 1'b1;
        tick(); hist_clr = 1'b0;
        din = 32'h0000_0100; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        din = 32'h0100_0000; start = 1'b1;
        tick(); start = 1'b0;
        @(negedge clk); check("t6_hist_44", int'(err_hist), 8'h44);
        tick(); tick(); tick();
        din = 32'h0000_0010; start = 1'b1; hist_clr = 1'b1;
        tick(); start = 1'b0; hist_clr = 1'b0;
        @(negedge clk); check("t6_hist_02", int'(err_hist), 8'h02);
        tick(); tick(); tick();
`endif

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
